regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_wb_fifo.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  // Entries are sized for the widest supported result; narrower results are zero-extended.
  localparam int unsigned MaxDataW = 64;

  typedef struct packed {
    logic [RegAddrW-1:0] waddr;
    logic [MaxDataW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source result buffer: Depth-entry FIFO (Depth a power of two) with flush.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      push_i,
  input  wb_entry_t wentry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [PtrW:0]   cnt_q;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wentry_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Buffers functional-unit results per source and arbitrates them round-robin onto the
// register-file write ports. Define REGFILE_WB_STALL_CNT_EN to add the stall_cnt_o counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_SOURCES     = 4,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_SOURCES-1:0]                src_valid_i,
  output logic [NR_SOURCES-1:0]                src_ready_o,
  input  logic [NR_SOURCES*RegAddrW-1:0]       src_waddr_i,
  input  logic [NR_SOURCES*DATA_WIDTH-1:0]     src_wdata_i,
  output logic [NR_WRITE_PORTS*RegAddrW-1:0]   waddr_o,
  output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WRITE_PORTS-1:0]            we_o
`ifdef REGFILE_WB_STALL_CNT_EN
  ,
  output logic [31:0]                          stall_cnt_o
`endif
);

  localparam int unsigned RrW = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;

  logic [NR_SOURCES-1:0] full, empty, push, pop;
  wb_entry_t             head [NR_SOURCES];
  logic [RrW-1:0]        rr_q, rr_d;

  assign src_ready_o = ~full & {NR_SOURCES{~flush_i}};

  for (genvar s = 0; s < NR_SOURCES; s++) begin : g_src
    wb_entry_t wentry;
    assign wentry.waddr = src_waddr_i[s*RegAddrW +: RegAddrW];
    assign wentry.wdata = MaxDataW'(src_wdata_i[s*DATA_WIDTH +: DATA_WIDTH]);
    // Writes to x0 complete the handshake but are never stored.
    assign push[s] = src_valid_i[s] & src_ready_o[s] & (wentry.waddr != '0);

    wb_fifo #(
      .Depth(FIFO_DEPTH)
    ) u_wb_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[s]),
      .wentry_i(wentry),
      .pop_i   (pop[s]),
      .full_o  (full[s]),
      .empty_o (empty[s]),
      .head_o  (head[s])
    );
  end

  // Each port takes the first head in scan order from rr_q that is not yet granted and
  // does not collide with an address already granted to a lower port.
  always_comb begin
    logic [RrW:0]   sum;
    logic [RrW-1:0] src;
    logic           found;
    logic           conflict;
    sum      = '0;
    src      = '0;
    found    = 1'b0;
    conflict = 1'b0;
    pop      = '0;
    we_o     = '0;
    waddr_o  = '0;
    wdata_o  = '0;
    rr_d     = rr_q;
    for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NR_SOURCES; i++) begin
        sum = {1'b0, rr_q} + (RrW+1)'(i);
        if (sum >= (RrW+1)'(NR_SOURCES)) sum = sum - (RrW+1)'(NR_SOURCES);
        src = sum[RrW-1:0];
        conflict = 1'b0;
        for (int unsigned q = 0; q < p; q++) begin
          if (we_o[q] && (waddr_o[q*RegAddrW +: RegAddrW] == head[src].waddr)) conflict = 1'b1;
        end
        if (!flush_i && !found && !empty[src] && !pop[src] && !conflict) begin
          found    = 1'b1;
          pop[src] = 1'b1;
          we_o[p]  = 1'b1;
          waddr_o[p*RegAddrW +: RegAddrW]     = head[src].waddr;
          wdata_o[p*DATA_WIDTH +: DATA_WIDTH] = head[src].wdata[DATA_WIDTH-1:0];
          rr_d = (src == RrW'(NR_SOURCES - 1)) ? '0 : src + RrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

`ifdef REGFILE_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((|(src_valid_i & ~src_ready_o)) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int DW = 64;
  localparam int FD = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [NS-1:0]    valid;
  logic [NS-1:0]    ready;
  logic [NS*5-1:0]  waddr_in;
  logic [NS*DW-1:0] wdata_in;
  logic [NW*5-1:0]  waddr;
  logic [NW*DW-1:0] wdata;
  logic [NW-1:0]    we;
`ifdef REGFILE_WB_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NR_SOURCES    (NS),
    .NR_WRITE_PORTS(NW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .src_valid_i(valid),
    .src_ready_o(ready),
    .src_waddr_i(waddr_in),
    .src_wdata_i(wdata_in),
    .waddr_o    (waddr),
    .wdata_o    (wdata),
    .we_o       (we)
`ifdef REGFILE_WB_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        mq [NS][$];
  int          rr_m;
  int unsigned stall_m;
  logic [4:0]  wlog [$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input logic full_reset);
    for (int s = 0; s < NS; s++) mq[s].delete();
    if (full_reset) begin
      rr_m    = 0;
      stall_m = 0;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input logic [NS-1:0] v, input logic [NS*5-1:0] a,
                       input logic [NS*DW-1:0] d, input logic fl);
    logic [NS-1:0]    exp_rdy;
    logic [NW-1:0]    exp_we;
    logic [NW*5-1:0]  exp_a;
    logic [NW*DW-1:0] exp_d;
    int               gsrc [$];
    int               s;
    logic             clash;
    ent_t             e;
    @(negedge clk);
    valid = v; waddr_in = a; wdata_in = d; flush = fl;
    #1;
    exp_we = '0; exp_a = '0; exp_d = '0;
    for (int k = 0; k < NS; k++) exp_rdy[k] = !fl && (mq[k].size() < FD);
    if (!fl) begin
      for (int i = 0; i < NS; i++) begin
        s = (rr_m + i) % NS;
        if (mq[s].size() > 0 && gsrc.size() < NW) begin
          clash = 1'b0;
          foreach (gsrc[g]) if (mq[gsrc[g]][0].a == mq[s][0].a) clash = 1'b1;
          if (!clash) begin
            exp_we[gsrc.size()] = 1'b1;
            exp_a[gsrc.size()*5 +: 5]   = mq[s][0].a;
            exp_d[gsrc.size()*DW +: DW] = mq[s][0].d;
            gsrc.push_back(s);
          end
        end
      end
    end
    check("ready", ready, exp_rdy);
    check("we", we, exp_we);
    check("waddr", waddr, exp_a);
    check("wdata", wdata, exp_d);
`ifdef REGFILE_WB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
`endif
    for (int p = 0; p < NW; p++) if (we[p]) wlog.push_back(waddr[p*5 +: 5]);
    if ((|(v & ~exp_rdy)) && stall_m != 32'hffff_ffff) stall_m++;
    foreach (gsrc[g]) void'(mq[gsrc[g]].pop_front());
    if (gsrc.size() > 0) rr_m = (gsrc[gsrc.size()-1] + 1) % NS;
    for (int k = 0; k < NS; k++) begin
      if (v[k] && exp_rdy[k] && a[k*5 +: 5] != 5'd0) begin
        e.a = a[k*5 +: 5];
        e.d = d[k*DW +: DW];
        mq[k].push_back(e);
      end
    end
    if (fl) model_clear(1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = '0; flush = 1'b0;
    #1;
    check("rst_we", we, '0);
    check("rst_waddr", waddr, '0);
    check("rst_wdata", wdata, '0);
`ifdef REGFILE_WB_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, '0);
`endif
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [NS*5-1:0] addrs(input int a0, input int a1, input int a2,
                                            input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [NS*DW-1:0] datas(input logic [63:0] d0, input logic [63:0] d1,
                                             input logic [63:0] d2, input logic [63:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic int logged(input int addr);
    int n = 0;
    foreach (wlog[i]) if (wlog[i] == 5'(addr)) n++;
    return n;
  endfunction

  initial begin : main
    logic [NS-1:0]    v;
    logic [NS*5-1:0]  a;
    logic [NS*DW-1:0] d;
    logic             fl;
    logic [4:0]       order [$];
    rst_n = 1'b0; flush = 1'b0; valid = '0; waddr_in = '0; wdata_in = '0;
    model_clear(1'b1);
    apply_reset();

    // Single result from source 1.
    cycle(4'b0010, addrs(0, 5, 0, 0), datas(0, 64'hA, 0, 0), 1'b0);
    idle(1);
    check("single_we", we, 2'b01);
    check("single_waddr", waddr[4:0], 5'd5);
    check("single_wdata", wdata[63:0], 64'hA);

    // Round robin across all four sources.
    apply_reset();
    cycle(4'b1111, addrs(1, 2, 3, 4), datas(1, 2, 3, 4), 1'b0);
    idle(1);
    check("rr_first", waddr, {5'd2, 5'd1});
    idle(1);
    check("rr_second", waddr, {5'd4, 5'd3});
    cycle(4'b1111, addrs(5, 6, 7, 8), datas(5, 6, 7, 8), 1'b0);
    idle(1);
    check("rr_wrap", waddr, {5'd6, 5'd5});
    idle(2);

    // Same destination from sources 0 and 2.
    apply_reset();
    cycle(4'b0101, addrs(7, 0, 7, 0), datas(64'h11, 0, 64'h22, 0), 1'b0);
    idle(1);
    check("conf_we0", we, 2'b01);
    check("conf_data0", wdata[63:0], 64'h11);
    idle(1);
    check("conf_we1", we, 2'b01);
    check("conf_data1", wdata[63:0], 64'h22);

    // Backpressure on source 0 while sources 1..3 hog the ports.
    apply_reset();
    cycle(4'b0001, addrs(9, 0, 0, 0), datas(64'h9, 0, 0, 0), 1'b0);
    idle(1);
    wlog.delete();
    cycle(4'b1111, addrs(10, 1, 2, 3), datas(64'h100, 1, 2, 3), 1'b0);
    cycle(4'b1111, addrs(11, 1, 2, 3), datas(64'h101, 1, 2, 3), 1'b0);
    cycle(4'b1111, addrs(12, 1, 2, 3), datas(64'h102, 1, 2, 3), 1'b0);
    check("bp_ready_low", ready[0], 1'b0);
    cycle(4'b1111, addrs(12, 1, 2, 3), datas(64'h102, 1, 2, 3), 1'b0);
    idle(8);
    foreach (wlog[i]) if (wlog[i] >= 5'd10 && wlog[i] <= 5'd12) order.push_back(wlog[i]);
    check("bp_count", order.size(), 3);
    for (int i = 0; i < 3; i++) check("bp_order", (i < order.size()) ? order[i] : 5'd0, 10 + i);

    // Flush of buffered results and an x0 write.
    apply_reset();
    wlog.delete();
    cycle(4'b0011, addrs(20, 21, 0, 0), datas(64'h20, 64'h21, 0, 0), 1'b0);
    cycle('0, '0, '0, 1'b1);
    cycle(4'b0100, addrs(0, 0, 0, 0), datas(0, 0, 64'hDEAD, 0), 1'b0);
    idle(3);
    check("flush_no_write", logged(20) + logged(21), 0);
    check("x0_no_write", logged(0), 0);

    // Reset with buffered data.
    cycle(4'b1111, addrs(25, 26, 27, 28), datas(25, 26, 27, 28), 1'b0);
    wlog.delete();
    apply_reset();
    cycle('0, '0, '0, 1'b0);
    check("rst_ready_ones", ready, 4'hF);
    idle(4);
    check("rst_no_stale", logged(25) + logged(26) + logged(27) + logged(28), 0);

    // Randomised traffic with small address range to provoke conflicts and x0 pushes.
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NS; s++) begin
        v[s] = ($urandom_range(0, 9) < 6);
        a[s*5 +: 5] = 5'($urandom_range(0, 7));
        d[s*DW +: DW] = {$urandom, $urandom};
      end
      fl = ($urandom_range(0, 19) == 0);
      cycle(v, a, d, fl);
      if (n == 200) apply_reset();
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
